// File: rtl/d_ff_response_checker_if.sv
// -----------------------------------------------------------------------------
// d_ff_response_checker_if
// Groups the signals between the environment and the D flip-flop response
// checker.
//   observed side (toward the checker): dut_rst, d_in, d_out, enable, clr_stats
//   result side   (from the checker)  : pass_cnt, fail_cnt, err, first_err_idx,
//                                       state, done
// The master modport is the environment that drives the observed flop signals
// and reads the results. The slave modport is the checker itself.
// -----------------------------------------------------------------------------
interface d_ff_response_checker_if #(
    parameter int CW = 16
);
    logic          dut_rst;
    logic          d_in;
    logic          d_out;
    logic          enable;
    logic          clr_stats;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          err;
    logic [CW-1:0] first_err_idx;
    logic [1:0]    state;
    logic          done;

    modport master (
        output dut_rst, d_in, d_out, enable, clr_stats,
        input  pass_cnt, fail_cnt, err, first_err_idx, state, done
    );

    modport slave (
        input  dut_rst, d_in, d_out, enable, clr_stats,
        output pass_cnt, fail_cnt, err, first_err_idx, state, done
    );
endinterface

// File: rtl/d_ff_response_checker.sv
// -----------------------------------------------------------------------------
// d_ff_response_checker
// Watches a D flip-flop with synchronous active-high reset and checks that its
// output follows (dut_rst ? 0 : d_in) with one clock of latency. A run is
// IDLE -> PRIME (one cycle to load the expectation) -> CHECK (NUM_CHECKS
// compares) -> DONE. Pass/fail counters saturate; the first failing compare
// index is captured in a sticky error record.
// Ports:
//   clk   : single rising-edge clock
//   rst   : asynchronous active-low reset of the checker
//   io    : slave side of d_ff_response_checker_if (observed flop signals in,
//           counters / err / first_err_idx / state / done out, all registered)
// -----------------------------------------------------------------------------
module d_ff_response_checker #(
    parameter logic [15:0] NUM_CHECKS = 16'd1000,
    parameter int          CW         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    d_ff_response_checker_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic          exp_r;
    logic [15:0]   idx_r;
    logic [15:0]   idx_next_s;
    logic          cmp_s;
    logic          mism_s;
    logic [CW-1:0] pass_r;
    logic [CW-1:0] fail_r;
    logic [CW-1:0] fei_r;
    logic          err_r;
    logic          done_r;

    // Next-state, compare-enable and compare-index logic of the run FSM.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = 16'd0;
        cmp_s        = 1'b0;
        mism_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (io.enable) begin
                    state_next_s = PRIME;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRIME: begin
                if (io.enable) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CHECK: begin
                if (!io.enable) begin
                    // Abort: no compare this cycle, index restarts at 0.
                    state_next_s = IDLE;
                end else begin
                    cmp_s  = 1'b1;
                    mism_s = (io.d_out != exp_r);
                    if (idx_r == (NUM_CHECKS - 16'd1)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = CHECK;
                        idx_next_s   = idx_r + 16'd1;
                    end
                end
            end
            DONE: begin
                if (io.enable) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Reference flop: expectation for the next cycle's d_out, always running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_r <= 1'b0;
        end else begin
            exp_r <= io.dut_rst ? 1'b0 : io.d_in;
        end
    end

    // FSM state, compare index and registered done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= 16'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            done_r  <= (state_next_s == DONE);
        end
    end

    // Statistics: clear has priority and discards a simultaneous compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_r <= {CW{1'b0}};
            fail_r <= {CW{1'b0}};
            fei_r  <= {CW{1'b0}};
            err_r  <= 1'b0;
        end else if (io.clr_stats) begin
            pass_r <= {CW{1'b0}};
            fail_r <= {CW{1'b0}};
            fei_r  <= {CW{1'b0}};
            err_r  <= 1'b0;
        end else if (cmp_s) begin
            if (mism_s) begin
                fail_r <= sat_inc(fail_r);
                if (!err_r) begin
                    err_r <= 1'b1;
                    fei_r <= CW'(idx_r);
                end else begin
                    err_r <= err_r;
                    fei_r <= fei_r;
                end
            end else begin
                pass_r <= sat_inc(pass_r);
            end
        end else begin
            pass_r <= pass_r;
            fail_r <= fail_r;
            fei_r  <= fei_r;
            err_r  <= err_r;
        end
    end

    assign io.pass_cnt      = pass_r;
    assign io.fail_cnt      = fail_r;
    assign io.err           = err_r;
    assign io.first_err_idx = fei_r;
    assign io.state         = state_r;
    assign io.done          = done_r;

endmodule

// File: doc/d_ff_response_checker.md
D_FF_RESPONSE_CHECKER -- requirements
Module: d_ff_response_checker

Interface
REQ-001 Parameter NUM_CHECKS, default 16'd1000, number of compared cycles before the run completes; legal range 1..65535.
REQ-002 Parameter CW, default 16, width of every counter output.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset of the checker itself (rst=0 resets).
REQ-005 dut_rst  input  1  observed synchronous active-high reset of the flop under check.
REQ-006 d_in  input  1  observed data input of the flop under check.
REQ-007 d_out  input  1  observed data output of the flop under check.
REQ-008 enable  input  1  level; 1 = run checking, 0 = abort to IDLE.
REQ-009 clr_stats  input  1  synchronous single-cycle clear of counters and error capture.
REQ-010 pass_cnt  output  CW  number of compared cycles where d_out matched expected.
REQ-011 fail_cnt  output  CW  number of compared cycles where d_out mismatched.
REQ-012 err  output  1  sticky; 1 once any mismatch has occurred since last clear/reset.
REQ-013 first_err_idx  output  CW  compare index (0-based) of the first mismatch; valid when err=1.
REQ-014 state  output  2  FSM state encoding: IDLE=0, PRIME=1, CHECK=2, DONE=3.
REQ-015 done  output  1  high while state=DONE.

Function
REQ-016 Reference model: exp_q SHALL register (dut_rst ? 1'b0 : d_in) every rising edge, independent of FSM state.
REQ-017 IDLE: when enable=1, next state PRIME; else stay.
REQ-018 PRIME: one cycle only, loads exp_q so first compare uses a valid expectation; next state CHECK (or IDLE if enable=0).
REQ-019 CHECK: each cycle compare d_out to exp_q; match -> pass_cnt+1, mismatch -> fail_cnt+1; compare index idx_q SHALL increment each compared cycle.
REQ-020 CHECK -> DONE on the cycle the NUM_CHECKS-th compare is performed (idx_q = NUM_CHECKS-1); that compare SHALL still be counted.
REQ-021 DONE: no compares, counters frozen; enable=0 -> IDLE; enable=1 stays DONE.
REQ-022 enable=0 in PRIME or CHECK -> IDLE next cycle; no compare on that cycle; counters and err retained; idx_q reset to 0.
REQ-023 On first mismatch with err=0: err<=1, first_err_idx<=idx_q; later mismatches SHALL NOT update first_err_idx.
REQ-024 pass_cnt and fail_cnt SHALL saturate at all-ones; no wrap-around.
REQ-025 clr_stats=1 clears pass_cnt, fail_cnt, err, first_err_idx to 0 on that edge; clear wins over a simultaneous compare (that compare is discarded); FSM state and idx_q unaffected.
REQ-026 Compare latency: d_out at edge N is checked against d_in/dut_rst sampled at edge N-1 (one-cycle flop latency).
REQ-027 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, exp_q=0, idx_q=0, pass_cnt=0, fail_cnt=0, err=0, first_err_idx=0, done=0.
REQ-029 rst deassertion is synchronous to clk externally; first FSM transition occurs on the first rising edge with rst=1.
REQ-030 rst asserted mid-CHECK SHALL discard the run entirely; no counter retains pre-reset value.

Verification
REQ-031 NUM_CHECKS=8, correct flop, d_in toggling 0,1,0,1..., enable=1 -> after PRIME + 8 compares: pass_cnt=8, fail_cnt=0, err=0, done=1.
REQ-032 NUM_CHECKS=8, flop with d_out forced 0 during compares 3 and 5 while exp=1 -> fail_cnt=2, pass_cnt=6, err=1, first_err_idx=3.
REQ-033 dut_rst=1 pulsed for 2 cycles mid-run with correct flop (d_out=0 following) -> no failures counted; pass_cnt increments every compare.
REQ-034 enable dropped after 4 compares, reasserted -> state IDLE->PRIME->CHECK, pass_cnt continues from 4, idx restarts at 0.
REQ-035 clr_stats asserted on the same cycle as a mismatch -> fail_cnt=0, err=0 after edge; next mismatch sets first_err_idx to current idx.
REQ-036 CW=4, NUM_CHECKS=20, correct flop -> pass_cnt saturates at 4'hF; rst=0 mid-run -> all outputs 0 immediately, without waiting for clk.
